// File: rtl/sfx_pkg.sv
// ============================================================================
// Module   : sfx_pkg
// Purpose  : Shared constants, state encodings and note table for the sfx
//            sequencer family.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sfx_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NOTE = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic MODE_ARP   = 1'b0;
    localparam logic MODE_ALARM = 1'b1;

    localparam int IDX_W        = 4;
    localparam int NOTE_CNT     = 12;
    localparam int NOTE_MAX_IDX = 11;

    localparam int ALARM_LEN = 4;
    localparam logic [IDX_W-1:0] ALARM_PHRASE [ALARM_LEN] = '{4'd8, 4'd6, 4'd4, 4'd1};

    // Index 0 is silence; the rest is a C-major run from C4 upward.
    function automatic int note_freq(input int idx);
        case (idx)
            1:       return 261;
            2:       return 294;
            3:       return 330;
            4:       return 349;
            5:       return 392;
            6:       return 440;
            7:       return 494;
            8:       return 524;
            9:       return 588;
            10:      return 660;
            11:      return 698;
            default: return 0;
        endcase
    endfunction

    function automatic int note_div_of(input int idx, input int clk_hz);
        int i;
        int f;
        i = (idx > NOTE_MAX_IDX) ? NOTE_MAX_IDX : idx;
        f = note_freq(i);
        return (f == 0) ? 0 : (clk_hz / f) / 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sfx_tick_prescaler.sv
// ============================================================================
// Module   : sfx_tick_prescaler
// Purpose  : Free-running 0..TICK_DIV-1 counter with synchronous clear and a
//            tick strobe on the terminal count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfx_tick_prescaler #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || (cnt_q == C_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/sfx_note_sequencer.sv
// ============================================================================
// Module   : sfx_note_sequencer
// Purpose  : Score-event accumulator that plays an ascending arpeggio on commit
//            and a pre-empting descending phrase on alarm, driving note_div.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfx_note_sequencer
    import sfx_pkg::*;
#(
    parameter int TICK_DIV    = 12_500_000,
    parameter int NOTE_TICKS  = 2,
    parameter int GAP_TICKS   = 1,
    parameter int MAX_COUNT   = 15,
    parameter int CNT_W       = 4,
    parameter int DIV_W       = 22,
    parameter int BUZZ_CLK_HZ = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       event_inc_i,
    input  logic             commit_i,
    input  logic             alarm_i,
    output logic [DIV_W-1:0] note_div_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int TK_W  = 16;
    localparam int SUM_W = CNT_W + 4;
    localparam logic [SUM_W-1:0] C_MAX_SUM = SUM_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_COUNT);

    logic [1:0]       state_q,    state_d;
    logic             mode_q,     mode_d;
    logic [CNT_W-1:0] step_q,     step_d;
    logic [CNT_W-1:0] len_q,      len_d;
    logic [TK_W-1:0]  ticks_q,    ticks_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [DIV_W-1:0] note_div_q, note_div_d;
    logic             done_q,     done_d;

    logic             w_tick;
    logic             w_start;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] w_count_acc;
    logic [CNT_W-1:0] w_inc_sat;
    logic             w_note_end;
    logic             w_gap_end;
    logic             w_seq_adv;
    logic             w_last;
    logic [CNT_W:0]   w_arp_idx;
    logic [IDX_W-1:0] w_idx;
    logic [DIV_W-1:0] w_table [NOTE_CNT];

    for (genvar k = 0; k < NOTE_CNT; k++) begin : g_table
        assign w_table[k] = DIV_W'(note_div_of(k, BUZZ_CLK_HZ));
    end

    // Restarting the prescaler on every start keeps each note exactly
    // NOTE_TICKS*TICK_DIV cycles long regardless of prior phase.
    assign w_start = alarm_i | (commit_i & (state_q == ST_IDLE) & (count_q != '0));

    sfx_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .clear_i (w_start),
        .tick_o  (w_tick)
    );

    assign w_sum       = SUM_W'(count_q) + SUM_W'(event_inc_i);
    assign w_count_acc = (w_sum > C_MAX_SUM) ? C_MAX_CNT : w_sum[CNT_W-1:0];
    assign w_inc_sat   = (SUM_W'(event_inc_i) > C_MAX_SUM) ? C_MAX_CNT
                                                            : CNT_W'(event_inc_i);

    assign w_note_end = (state_q == ST_NOTE) && w_tick && (ticks_q == TK_W'(NOTE_TICKS - 1));
    assign w_gap_end  = (state_q == ST_GAP)  && w_tick && (ticks_q == TK_W'(GAP_TICKS - 1));
    assign w_seq_adv  = (GAP_TICKS == 0) ? w_note_end : w_gap_end;
    assign w_last     = (step_q == (len_q - 1'b1));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        step_d  = step_q;
        len_d   = len_q;
        ticks_d = ticks_q;
        count_d = w_count_acc;
        done_d  = 1'b0;

        if (alarm_i) begin
            mode_d  = MODE_ALARM;
            step_d  = '0;
            len_d   = CNT_W'(ALARM_LEN);
            ticks_d = '0;
            state_d = ST_NOTE;
            count_d = w_inc_sat;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (commit_i) begin
                        if (count_q != '0) begin
                            mode_d  = MODE_ARP;
                            step_d  = '0;
                            len_d   = count_q;
                            ticks_d = '0;
                            state_d = ST_NOTE;
                            count_d = w_inc_sat;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_NOTE: begin
                    if (w_note_end) begin
                        ticks_d = '0;
                        state_d = ST_GAP;
                    end else if (w_tick) begin
                        ticks_d = ticks_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_gap_end) begin
                        ticks_d = '0;
                    end else if (w_tick) begin
                        ticks_d = ticks_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // With no gap configured this overrides the NOTE->GAP move above.
            if (w_seq_adv) begin
                if (w_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    step_d  = step_q + 1'b1;
                    state_d = ST_NOTE;
                end
            end
        end
    end

    always_comb begin
        w_arp_idx = {1'b0, step_d} + 1'b1;
        if (mode_d == MODE_ALARM) begin
            w_idx = ALARM_PHRASE[step_d[1:0]];
        end else if (w_arp_idx > (CNT_W + 1)'(NOTE_MAX_IDX)) begin
            w_idx = IDX_W'(NOTE_MAX_IDX);
        end else begin
            w_idx = IDX_W'(w_arp_idx);
        end
        note_div_d = (state_d == ST_NOTE) ? w_table[w_idx] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_ARP;
            step_q     <= '0;
            len_q      <= '0;
            ticks_q    <= '0;
            count_q    <= '0;
            note_div_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            step_q     <= step_d;
            len_q      <= len_d;
            ticks_q    <= ticks_d;
            count_q    <= count_d;
            note_div_q <= note_div_d;
            done_q     <= done_d;
        end
    end

    assign note_div_o = note_div_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;
    assign count_o    = count_q;

endmodule

`default_nettype wire

// File: tb/tb_sfx_note_sequencer.sv
// ============================================================================
// Module   : tb_sfx_note_sequencer
// Purpose  : Directed self-checking bench for sfx_note_sequencer (12 cycles
//            per note: TICK_DIV=4, NOTE_TICKS=2, GAP_TICKS=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sfx_note_sequencer;

    localparam int DIV_W = 22;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       event_inc = 3'd0;
    logic             commit = 1'b0;
    logic             alarm = 1'b0;
    logic [DIV_W-1:0] note_div;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_err    = 0;

    // 50 MHz / f, truncated, for silence plus the eleven table notes.
    int tbl [12] = '{0, 191570, 170068, 151515, 143266, 127551,
                     113636, 101214, 95419, 85034, 75757, 71633};

    sfx_note_sequencer #(
        .TICK_DIV    (4),
        .NOTE_TICKS  (2),
        .GAP_TICKS   (1),
        .MAX_COUNT   (15),
        .CNT_W       (CNT_W),
        .DIV_W       (DIV_W),
        .BUZZ_CLK_HZ (100_000_000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .event_inc_i (event_inc),
        .commit_i    (commit),
        .alarm_i     (alarm),
        .note_div_o  (note_div),
        .busy_o      (busy),
        .done_o      (done),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int flag;
        int ni;
        int ph;
        int s;
        int done_cnt;

        // ---------------- reset and idle ----------------
        repeat (3) step();
        chk("rst_note_div", 32'(note_div), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(count), 0);
        rst = 1'b0;
        step();
        chk("idle_note_div", 32'(note_div), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_count", 32'(count), 0);
        flag = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (note_div != '0 || busy || done || count != '0) flag = 1;
        end
        chk("idle_stable", 32'(flag), 0);

        // ---------------- commit with count = 0 ----------------
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("empty_done", 32'(done), 1);
        chk("empty_busy", 32'(busy), 0);
        step();
        chk("empty_done_clr", 32'(done), 0);
        chk("empty_busy2", 32'(busy), 0);

        // ---------------- accumulate 3 and commit ----------------
        event_inc = 3'd1;
        repeat (3) step();
        event_inc = 3'd0;
        chk("acc_count3", 32'(count), 3);
        commit = 1'b1;
        for (int k = 1; k <= 37; k++) begin
            step();
            commit = 1'b0;
            if (k == 21) event_inc = 3'd0;
            if (k == 1) chk("arp_count_cleared", 32'(count), 0);
            if (k <= 36) begin
                ni = (k - 1) / 12;
                ph = (k - 1) % 12;
                chk("arp3_note_div", 32'(note_div), (ph < 8) ? tbl[ni + 1] : 0);
                chk("arp3_busy", 32'(busy), 1);
                chk("arp3_no_done", 32'(done), 0);
            end else begin
                chk("arp3_end_note_div", 32'(note_div), 0);
                chk("arp3_end_busy", 32'(busy), 0);
                chk("arp3_end_done", 32'(done), 1);
                chk("busy_accum_count", 32'(count), 2);
            end
            if (k == 15) commit = 1'b1;
            if (k == 20) event_inc = 3'd2;
        end

        // ---------------- commit with same-cycle increment ----------------
        commit = 1'b1;
        event_inc = 3'd2;
        for (int k = 1; k <= 25; k++) begin
            step();
            commit = 1'b0;
            event_inc = 3'd0;
            if (k == 1) begin
                chk("samecyc_count", 32'(count), 2);
                chk("arp2_note1", 32'(note_div), tbl[1]);
            end
            if (k == 9)  chk("arp2_gap1", 32'(note_div), 0);
            if (k == 13) chk("arp2_note2", 32'(note_div), tbl[2]);
            if (k == 24) chk("arp2_done_early", 32'(done), 0);
            if (k == 25) begin
                chk("arp2_done", 32'(done), 1);
                chk("arp2_busy", 32'(busy), 0);
            end
        end

        // ---------------- saturation and index clamp ----------------
        event_inc = 3'd7;
        repeat (5) step();
        event_inc = 3'd0;
        chk("sat_count", 32'(count), 15);
        commit = 1'b1;
        for (int k = 1; k <= 181; k++) begin
            step();
            commit = 1'b0;
            s = (k - 1) / 12;
            if (k == 1) chk("sat_count_cleared", 32'(count), 0);
            if (k <= 180 && (k - 1) % 12 == 0)
                chk("sat_note", 32'(note_div), tbl[(s + 1 > 11) ? 11 : s + 1]);
            if ((k - 1) % 12 == 8) chk("sat_gap", 32'(note_div), 0);
            if (k == 180) chk("sat_no_done", 32'(done), 0);
            if (k == 181) begin
                chk("sat_done", 32'(done), 1);
                chk("sat_busy", 32'(busy), 0);
            end
        end

        // ---------------- alarm pre-empts second arpeggio note ----------------
        event_inc = 3'd1;
        repeat (3) step();
        event_inc = 3'd0;
        commit = 1'b1;
        done_cnt = 0;
        for (int k = 1; k <= 70; k++) begin
            step();
            commit = 1'b0;
            if (k == 16) begin
                alarm = 1'b0;
                event_inc = 3'd0;
            end
            if (done) done_cnt++;
            if (k == 13) chk("pre_alarm_note2", 32'(note_div), tbl[2]);
            if (k == 16) begin
                chk("alarm_note8", 32'(note_div), tbl[8]);
                chk("alarm_busy", 32'(busy), 1);
                chk("alarm_count", 32'(count), 1);
            end
            if (k == 24) chk("alarm_gap", 32'(note_div), 0);
            if (k == 28) chk("alarm_note6", 32'(note_div), tbl[6]);
            if (k == 40) chk("alarm_note4", 32'(note_div), tbl[4]);
            if (k == 52) chk("alarm_note1", 32'(note_div), tbl[1]);
            if (k == 64) begin
                chk("alarm_done", 32'(done), 1);
                chk("alarm_end_busy", 32'(busy), 0);
            end
            if (k == 15) begin
                alarm = 1'b1;
                event_inc = 3'd1;
            end
        end
        chk("alarm_done_count", 32'(done_cnt), 1);

        // ---------------- alarm + commit together, then async reset ----------------
        alarm = 1'b1;
        commit = 1'b1;
        step();
        alarm = 1'b0;
        commit = 1'b0;
        chk("alarm_commit_note", 32'(note_div), tbl[8]);
        chk("alarm_commit_count", 32'(count), 0);
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_note_div", 32'(note_div), 0);
        chk("async_rst_busy", 32'(busy), 0);
        step();
        step();
        rst = 1'b0;
        flag = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy || note_div != '0) flag = 1;
        end
        chk("post_rst_quiet", 32'(flag), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
